// File: rtl/paper_sequencer.sv
// Fetch/decode/control sequencer for the 2-bit paper processor.
// Optional PAPER_SINGLE_STEP_EN: FETCH waits for a step request.
module paper_sequencer #(
   parameter int AW = 2,
   parameter int DW = 2
) (
   input  logic          clock,
   input  logic          Resetter,
   output logic [AW-1:0] ram_addr,
   input  logic [DW-1:0] ram_data,
   input  logic          status,
   input  logic          step,
   output logic [AW-1:0] pc,
   output logic [DW-1:0] ir,
   output logic          inc_strobe,
   output logic          jump_taken,
   output logic          retire,
   output logic          halted
);

   typedef enum logic [1:0] {
      FETCH,
      DECODE,
      OPERAND,
      HALTED
   } state_t;

   localparam logic [1:0] OP_INC = 2'b00;
   localparam logic [1:0] OP_JNO = 2'b01;
   localparam logic [1:0] OP_HLT = 2'b10;

   state_t     state;
   logic [1:0] op;
   logic       go;

   assign op = ir[1:0];

`ifdef PAPER_SINGLE_STEP_EN
   assign go = step;
`else
   logic unused_step;
   assign unused_step = step;
   assign go = 1'b1;
`endif

   always_ff @(posedge clock) begin
      if (Resetter) begin
         state <= FETCH;
         pc    <= '0;
         ir    <= '0;
      end else begin
         unique case (state)
            FETCH: begin
               if (go) begin
                  ir    <= ram_data;
                  pc    <= pc + AW'(1);
                  state <= DECODE;
               end
            end
            DECODE: begin
               unique case (op)
                  OP_JNO:  state <= OPERAND;
                  OP_HLT:  state <= HALTED;
                  default: state <= FETCH;
               endcase
            end
            OPERAND: begin
               // status set means overflow: skip the target word
               pc    <= status ? pc + AW'(1) : ram_data[AW-1:0];
               state <= FETCH;
            end
            HALTED:  state <= HALTED;
            default: state <= FETCH;
         endcase
      end
   end

   assign ram_addr   = pc;
   assign inc_strobe = (state == DECODE) && (op == OP_INC);
   // a reset landing in OPERAND aborts the branch without any pulse
   assign jump_taken = (state == OPERAND) && !status && !Resetter;
   assign retire     = ((state == DECODE) && (op != OP_JNO))
                     || ((state == OPERAND) && !Resetter);
   assign halted     = (state == HALTED);

endmodule
